// File: rtl/ff_bank_multimode.sv
// ff_bank_multimode
//   A bank of WIDTH independent flip-flops that share one clock and one reset.
//   A run-time mode selects SR, JK, D or T behaviour for the whole bank, and
//   each bit has its own enable. When an SR-mode bit sees S=R=1, a fixed
//   policy resolves it, so the state never becomes X. These events are flagged
//   for one cycle and counted by a saturating counter for diagnostics.
//
// Parameters
//   WIDTH        number of flip-flop channels (>=1)
//   SR11_POLICY  SR-mode S=R=1 resolution: 0 hold, 1 force 0, 2 force 1
//   RESET_VAL    value loaded into q on reset
//   CNT_W        width of the conflict counter (>=1)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   mode          in   2'b00 SR, 2'b01 JK, 2'b10 D, 2'b11 T
//   en            in   per-bit enable, 0 holds the bit
//   a             in   S / J / D / T input per bit
//   b             in   R / K input per bit (ignored in D and T)
//   clr_cnt       in   synchronous clear of conflict_cnt
//   q             out  flip-flop state
//   qbar          out  registered complement of q
//   conflict      out  an SR S=R=1 occurred on an enabled bit at the last edge
//   conflict_cnt  out  saturating count of edges with a conflict
module ff_bank_multimode #(
  parameter int               WIDTH       = 8,
  parameter int               SR11_POLICY = 0,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] srSet, srClr, srBoth;

  // Next state for the whole bank. Enable masking is folded into each mode's
  // expression so disabled bits always keep q_q. In SR mode the S=R=1 bits are
  // folded into either the set or the clear mask, depending on the policy;
  // with the hold policy they appear in neither mask, so they keep their value.
  always_comb begin
    q_d    = q_q;
    srBoth = en & a & b;
    srSet  = en & a & ~b;
    srClr  = en & ~a & b;
    if (SR11_POLICY == 1) begin
      srClr = srClr | srBoth;
    end else if (SR11_POLICY == 2) begin
      srSet = srSet | srBoth;
    end
    case (mode_e'(mode))
      MODE_SR: q_d = (q_q & ~srClr) | srSet;
      MODE_JK: q_d = (en & ((a & ~q_q) | (~b & q_q))) | (~en & q_q);
      MODE_D:  q_d = (en & a) | (~en & q_q);
      MODE_T:  q_d = q_q ^ (en & a);
      default: q_d = q_q;
    endcase
  end

  // The conflict flag reflects only the current edge. The counter clear takes
  // priority over an increment, and the counter sticks at all-ones instead of
  // wrapping.
  always_comb begin
    conflict_d = (mode_e'(mode) == MODE_SR) && (|srBoth);
    cnt_d      = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (conflict_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // qbar has its own register, loaded from ~q_d, so it changes on the same
  // edge as q and stays an exact complement, including through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q        <= RESET_VAL;
      qbar_q     <= ~RESET_VAL;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      qbar_q     <= ~q_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign q            = q_q;
  assign qbar         = qbar_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// tb_ff_bank_multimode
//   Drives three copies of the bank with a shared input stimulus. Each copy
//   uses a different SR S=R=1 policy (hold, clear, set), and all use
//   RESET_VAL=A5. The first two copies have a 2-bit counter and the third has
//   a 3-bit counter. A per-bit behavioural model gives the expected q, qbar,
//   conflict and counter values for every copy after every edge or reset.
module tb_ff_bank_multimode;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] en, a, b;
  logic       clrCnt;

  logic [7:0] q0, q1, q2, qb0, qb1, qb2;
  logic       cf0, cf1, cf2;
  logic [1:0] cnt0, cnt1;
  logic [2:0] cnt2;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] mq[3];
  logic       mcf[3];
  int         mcnt[3];
  int         policy[3] = '{0, 1, 2};
  int         cntMax[3] = '{3, 3, 7};

  always #5 clk = ~clk;

  ff_bank_multimode #(.WIDTH(8), .SR11_POLICY(0), .RESET_VAL(8'hA5), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b), .clr_cnt(clrCnt),
    .q(q0), .qbar(qb0), .conflict(cf0), .conflict_cnt(cnt0));
  ff_bank_multimode #(.WIDTH(8), .SR11_POLICY(1), .RESET_VAL(8'hA5), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b), .clr_cnt(clrCnt),
    .q(q1), .qbar(qb1), .conflict(cf1), .conflict_cnt(cnt1));
  ff_bank_multimode #(.WIDTH(8), .SR11_POLICY(2), .RESET_VAL(8'hA5), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b), .clr_cnt(clrCnt),
    .q(q2), .qbar(qb2), .conflict(cf2), .conflict_cnt(cnt2));

  // Compares one observed value with one expected value and counts the
  // comparison. A mismatch is reported on a single line.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] obsQ(input int k);
    return (k == 0) ? {24'd0, q0} : (k == 1) ? {24'd0, q1} : {24'd0, q2};
  endfunction
  function automatic logic [31:0] obsQb(input int k);
    return (k == 0) ? {24'd0, qb0} : (k == 1) ? {24'd0, qb1} : {24'd0, qb2};
  endfunction
  function automatic logic [31:0] obsCf(input int k);
    return (k == 0) ? {31'd0, cf0} : (k == 1) ? {31'd0, cf1} : {31'd0, cf2};
  endfunction
  function automatic logic [31:0] obsCnt(input int k);
    return (k == 0) ? {30'd0, cnt0} : (k == 1) ? {30'd0, cnt1} : {29'd0, cnt2};
  endfunction

  // Checks every output of every copy against the model.
  task automatic checkAll(input string step);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("%s.q%0d", step, k), obsQ(k), {24'd0, mq[k]});
      checkOutput($sformatf("%s.qbar%0d", step, k), obsQb(k), {24'd0, ~mq[k]});
      checkOutput($sformatf("%s.conflict%0d", step, k), obsCf(k), {31'd0, mcf[k]});
      checkOutput($sformatf("%s.cnt%0d", step, k), obsCnt(k), mcnt[k]);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mq[k]   = 8'hA5;
      mcf[k]  = 1'b0;
      mcnt[k] = 0;
    end
  endtask

  // Computes one rising edge bit by bit from the flip-flop truth tables.
  task automatic modelEdge();
    logic anyConflict;
    logic nq;
    anyConflict = 1'b0;
    for (int i = 0; i < 8; i++)
      if (mode == 2'b00 && en[i] && a[i] && b[i]) anyConflict = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        nq = mq[k][i];
        if (en[i]) begin
          case (mode)
            2'b00: begin
              if (a[i] && !b[i]) nq = 1'b1;
              else if (!a[i] && b[i]) nq = 1'b0;
              else if (a[i] && b[i]) begin
                if (policy[k] == 1) nq = 1'b0;
                else if (policy[k] == 2) nq = 1'b1;
              end
            end
            2'b01: begin
              if (a[i] && !b[i]) nq = 1'b1;
              else if (!a[i] && b[i]) nq = 1'b0;
              else if (a[i] && b[i]) nq = !mq[k][i];
            end
            2'b10: nq = a[i];
            default: if (a[i]) nq = !mq[k][i];
          endcase
        end
        mq[k][i] = nq;
      end
      mcf[k] = anyConflict;
      if (clrCnt) mcnt[k] = 0;
      else if (anyConflict && mcnt[k] < cntMax[k]) mcnt[k] = mcnt[k] + 1;
    end
  endtask

  // Drives the inputs, waits for one rising edge, updates the model and checks
  // the outputs 1 time unit after the edge.
  task automatic applyStimulus(input string step, input logic [1:0] m, input logic [7:0] e,
                               input logic [7:0] aa, input logic [7:0] bb, input logic c);
    mode = m; en = e; a = aa; b = bb; clrCnt = c;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(step);
  endtask

  // Pulses reset between clock edges and checks that the outputs take their
  // reset values before any edge arrives.
  task automatic asyncReset(input string step);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkAll(step);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; mode = 2'b00; en = 8'h00; a = 8'h00; b = 8'h00; clrCnt = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    rst = 1'b1;

    // SR sequence: set/clear, hold, then S=R=1 under each policy
    applyStimulus("sr1", 2'b00, 8'hFF, 8'h0F, 8'hF0, 1'b0);
    applyStimulus("sr2", 2'b00, 8'hFF, 8'h00, 8'h00, 1'b0);
    applyStimulus("sr3", 2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0);

    // Reset mid-operation, while q is away from its reset value
    asyncReset("midReset");

    // JK toggle three times from 00, then T mode
    applyStimulus("jk0", 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("jk%0d", i + 1), 2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    applyStimulus("t1", 2'b11, 8'hFF, 8'h0F, 8'h00, 1'b0);

    // Enables in D mode
    applyStimulus("d0", 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    applyStimulus("d1", 2'b10, 8'h0F, 8'hFF, 8'h00, 1'b0);
    applyStimulus("d2", 2'b10, 8'h00, 8'h00, 8'hFF, 1'b0);

    // Counter saturation, then a clear while the conflict is still present
    applyStimulus("cnt0", 2'b00, 8'hFF, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++)
      applyStimulus($sformatf("cnt%0d", i + 1), 2'b00, 8'h01, 8'h81, 8'h01, 1'b0);
    applyStimulus("cntClr", 2'b00, 8'h01, 8'h01, 8'h01, 1'b1);

    // Policy sweep from AA
    applyStimulus("pol0", 2'b10, 8'hFF, 8'hAA, 8'h00, 1'b0);
    applyStimulus("pol1", 2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0);

    // Conflict on a disabled bit is ignored
    applyStimulus("noEn", 2'b00, 8'h0F, 8'hF0, 8'hF0, 1'b0);

    // Random operation with occasional clears and resets
    for (int n = 0; n < 400; n++) begin
      applyStimulus($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), 8'($urandom),
                    8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 49) == 0) asyncReset($sformatf("rndReset%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
